// File: rtl/requant_pkg.sv
// Shared constants, latched-config record and int8 saturation helper for the
// requantize-and-pack stage.
package requant_pkg;

    localparam int LANES   = 4;
    localparam int ACC_W   = 32;
    localparam int SCALE_W = 16;
    localparam int SHIFT_W = 5;
    localparam int TID_W   = 8;
    localparam int GLEN_W  = 16;
    localparam int PROD_W  = 48;
    localparam int Q_W     = PROD_W + 2;

    localparam logic signed [Q_W-1:0] INT8_MIN = Q_W'(-128);
    localparam logic signed [Q_W-1:0] INT8_MAX = Q_W'(127);

    typedef struct packed {
        logic [SCALE_W-1:0] scale;
        logic [SHIFT_W-1:0] shift;
        logic [7:0]         zero_point;
        logic               relu;
        logic [GLEN_W-1:0]  group_len;
    } cfg_t;

    function automatic logic [7:0] sat_int8(input logic signed [Q_W-1:0] v);
        logic [7:0] r;
        if (v > INT8_MAX) begin
            r = 8'h7f;
        end else if (v < INT8_MIN) begin
            r = 8'h80;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/requant_pack_stage_core.sv
// Two-stage requantizer: signed x unsigned scale product, then rounding shift,
// zero-point add, optional ReLU and int8 saturation. All registers hold while en=0.
module requant_core
    import requant_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               in_valid,
    input  logic [ACC_W-1:0]   in_data,
    input  logic [TID_W-1:0]   in_tid,
    input  logic               in_last,
    input  logic [SCALE_W-1:0] in_scale,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic [7:0]         in_zp,
    input  logic               in_relu,
    output logic               out_valid,
    output logic [7:0]         out_byte,
    output logic [TID_W-1:0]   out_tid,
    output logic               out_last
);

    logic signed [PROD_W-1:0] acc_ext, scale_ext, prod;
    logic signed [PROD_W:0]   rnd, biased, shifted;
    logic signed [Q_W-1:0]    q, zp_ext;
    logic [7:0]               q_byte;

    logic                     s1_valid_q, s1_valid_d;
    logic signed [PROD_W-1:0] s1_prod_q, s1_prod_d;
    logic [TID_W-1:0]         s1_tid_q, s1_tid_d;
    logic                     s1_last_q, s1_last_d;
    logic [SHIFT_W-1:0]       s1_shift_q, s1_shift_d;
    logic [7:0]               s1_zp_q, s1_zp_d;
    logic                     s1_relu_q, s1_relu_d;

    logic                     s2_valid_q, s2_valid_d;
    logic [7:0]               s2_byte_q, s2_byte_d;
    logic [TID_W-1:0]         s2_tid_q, s2_tid_d;
    logic                     s2_last_q, s2_last_d;

    // Both operands widened to the product width so the signed multiply is exact.
    always_comb begin : stage1_math
        acc_ext   = {{(PROD_W-ACC_W){in_data[ACC_W-1]}}, in_data};
        scale_ext = {{(PROD_W-SCALE_W){1'b0}}, in_scale};
        prod      = acc_ext * scale_ext;
    end

    always_comb begin : stage2_math
        rnd = '0;
        if (s1_shift_q != '0) begin
            rnd = {{PROD_W{1'b0}}, 1'b1} << (s1_shift_q - 5'd1);
        end
        biased  = {s1_prod_q[PROD_W-1], s1_prod_q} + rnd;
        shifted = biased >>> s1_shift_q;
        zp_ext  = {{(Q_W-8){s1_zp_q[7]}}, s1_zp_q};
        q       = {shifted[PROD_W], shifted} + zp_ext;
        if (s1_relu_q && (q < zp_ext)) begin
            q = zp_ext;
        end
        q_byte = sat_int8(q);
    end

    always_comb begin : next_state
        s1_valid_d = s1_valid_q;
        s1_prod_d  = s1_prod_q;
        s1_tid_d   = s1_tid_q;
        s1_last_d  = s1_last_q;
        s1_shift_d = s1_shift_q;
        s1_zp_d    = s1_zp_q;
        s1_relu_d  = s1_relu_q;
        s2_valid_d = s2_valid_q;
        s2_byte_d  = s2_byte_q;
        s2_tid_d   = s2_tid_q;
        s2_last_d  = s2_last_q;
        if (en) begin
            s1_valid_d = in_valid;
            s1_prod_d  = prod;
            s1_tid_d   = in_tid;
            s1_last_d  = in_last;
            s1_shift_d = in_shift;
            s1_zp_d    = in_zp;
            s1_relu_d  = in_relu;
            s2_valid_d = s1_valid_q;
            s2_byte_d  = q_byte;
            s2_tid_d   = s1_tid_q;
            s2_last_d  = s1_last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s1_tid_q   <= '0;
            s1_last_q  <= 1'b0;
            s1_shift_q <= '0;
            s1_zp_q    <= '0;
            s1_relu_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_byte_q  <= '0;
            s2_tid_q   <= '0;
            s2_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_prod_q  <= s1_prod_d;
            s1_tid_q   <= s1_tid_d;
            s1_last_q  <= s1_last_d;
            s1_shift_q <= s1_shift_d;
            s1_zp_q    <= s1_zp_d;
            s1_relu_q  <= s1_relu_d;
            s2_valid_q <= s2_valid_d;
            s2_byte_q  <= s2_byte_d;
            s2_tid_q   <= s2_tid_d;
            s2_last_q  <= s2_last_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_byte  = s2_byte_q;
    assign out_tid   = s2_tid_q;
    assign out_last  = s2_last_q;

endmodule

// File: rtl/requant_pack_stage.sv
// Requantizes 32-bit MAC results to int8 and packs four per output beat,
// closing each group of cfg_group_len results with TLAST.
module requant_pack_stage
    import requant_pkg::*;
#(
    parameter int C_ACC_WIDTH   = 32,
    parameter int C_SCALE_WIDTH = 16,
    parameter int C_LANES       = 4
)
(
    input  logic                     ACLK,
    input  logic                     ARESETN,
    output logic                     SD_AXIS_TREADY,
    input  logic [C_ACC_WIDTH-1:0]   SD_AXIS_TDATA,
    input  logic                     SD_AXIS_TLAST,
    input  logic                     SD_AXIS_TVALID,
    input  logic [7:0]               SD_AXIS_TID,
    output logic                     MO_AXIS_TVALID,
    output logic [31:0]              MO_AXIS_TDATA,
    output logic [3:0]               MO_AXIS_TKEEP,
    output logic                     MO_AXIS_TLAST,
    output logic [7:0]               MO_AXIS_TID,
    input  logic                     MO_AXIS_TREADY,
    input  logic [C_SCALE_WIDTH-1:0] cfg_scale,
    input  logic [4:0]               cfg_shift,
    input  logic [7:0]               cfg_zero_point,
    input  logic                     cfg_relu,
    input  logic [15:0]              cfg_group_len
);

    if (C_LANES != LANES || C_ACC_WIDTH != ACC_W || C_SCALE_WIDTH != SCALE_W) begin : g_param_check
        $error("requant_pack_stage: only 4 lanes, 32-bit acc and 16-bit scale are supported");
    end

    // Handshakes: a beat moves when VALID & READY at a rising edge; VALID never
    // waits on READY, and a raised VALID holds its payload until it moves.
    logic advance, accept;
    logic unused_tlast;

    cfg_t              cfg_live, cfg_eff, cfg_q, cfg_d;
    logic [GLEN_W-1:0] in_cnt_q, in_cnt_d, glen_eff;
    logic              in_last;

    logic              s2_valid, s2_last;
    logic [7:0]        s2_byte;
    logic [TID_W-1:0]  s2_tid;

    logic [1:0]        idx_q, idx_d;
    logic [23:0]       part_data_q, part_data_d;
    logic [TID_W-1:0]  part_tid_q, part_tid_d;
    logic              mo_valid_q, mo_valid_d;
    logic [31:0]       mo_data_q, mo_data_d;
    logic [3:0]        mo_keep_q, mo_keep_d;
    logic              mo_last_q, mo_last_d;
    logic [TID_W-1:0]  mo_tid_q, mo_tid_d;

    logic [31:0]       word;
    logic [3:0]        keep;
    logic [TID_W-1:0]  lane_tid;

    assign unused_tlast = SD_AXIS_TLAST;
    assign advance      = !mo_valid_q || MO_AXIS_TREADY;
    assign accept       = SD_AXIS_TVALID && SD_AXIS_TREADY;

    // Group end is decided at the input, so a group boundary travels with its
    // result and the next group's config can be latched while the last one drains.
    always_comb begin : cfg_and_count
        cfg_live = '{scale: cfg_scale, shift: cfg_shift, zero_point: cfg_zero_point,
                     relu: cfg_relu, group_len: cfg_group_len};
        cfg_eff  = (in_cnt_q == '0) ? cfg_live : cfg_q;
        glen_eff = (cfg_eff.group_len == '0) ? 16'd1 : cfg_eff.group_len;
        in_last  = (in_cnt_q + 16'd1) == glen_eff;
        cfg_d    = cfg_q;
        in_cnt_d = in_cnt_q;
        if (accept) begin
            cfg_d    = cfg_eff;
            in_cnt_d = in_last ? '0 : in_cnt_q + 16'd1;
        end
    end

    requant_core u_core (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .en        (advance),
        .in_valid  (accept),
        .in_data   (SD_AXIS_TDATA),
        .in_tid    (SD_AXIS_TID),
        .in_last   (in_last),
        .in_scale  (cfg_eff.scale),
        .in_shift  (cfg_eff.shift),
        .in_zp     (cfg_eff.zero_point),
        .in_relu   (cfg_eff.relu),
        .out_valid (s2_valid),
        .out_byte  (s2_byte),
        .out_tid   (s2_tid),
        .out_last  (s2_last)
    );

    always_comb begin : packer
        idx_d       = idx_q;
        part_data_d = part_data_q;
        part_tid_d  = part_tid_q;
        mo_valid_d  = mo_valid_q;
        mo_data_d   = mo_data_q;
        mo_keep_d   = mo_keep_q;
        mo_last_d   = mo_last_q;
        mo_tid_d    = mo_tid_q;
        word        = {8'h00, part_data_q};
        word[{idx_q, 3'b000} +: 8] = s2_byte;
        keep        = (4'b0010 << idx_q) - 4'b0001;
        lane_tid    = (idx_q == 2'd0) ? s2_tid : part_tid_q;
        if (advance) begin
            mo_valid_d = 1'b0;
            if (s2_valid) begin
                if (idx_q == 2'd3 || s2_last) begin
                    mo_valid_d  = 1'b1;
                    mo_data_d   = word;
                    mo_keep_d   = keep;
                    mo_last_d   = s2_last;
                    mo_tid_d    = lane_tid;
                    idx_d       = '0;
                    part_data_d = '0;
                end else begin
                    part_data_d = word[23:0];
                    part_tid_d  = lane_tid;
                    idx_d       = idx_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            cfg_q       <= '0;
            in_cnt_q    <= '0;
            idx_q       <= '0;
            part_data_q <= '0;
            part_tid_q  <= '0;
            mo_valid_q  <= 1'b0;
            mo_data_q   <= '0;
            mo_keep_q   <= '0;
            mo_last_q   <= 1'b0;
            mo_tid_q    <= '0;
        end else begin
            cfg_q       <= cfg_d;
            in_cnt_q    <= in_cnt_d;
            idx_q       <= idx_d;
            part_data_q <= part_data_d;
            part_tid_q  <= part_tid_d;
            mo_valid_q  <= mo_valid_d;
            mo_data_q   <= mo_data_d;
            mo_keep_q   <= mo_keep_d;
            mo_last_q   <= mo_last_d;
            mo_tid_q    <= mo_tid_d;
        end
    end

    assign SD_AXIS_TREADY = ARESETN && advance;
    assign MO_AXIS_TVALID = mo_valid_q;
    assign MO_AXIS_TDATA  = mo_data_q;
    assign MO_AXIS_TKEEP  = mo_keep_q;
    assign MO_AXIS_TLAST  = mo_last_q;
    assign MO_AXIS_TID    = mo_tid_q;

endmodule
